// File: rtl/core_issue.sv
// Operand-fetch/issue stage ahead of core_alu: reads rs1/rs2 from the 32x64 register file,
// registers the operands to the ALU, writes ALU results back, and handles RAW stall, bypass and redirect.
module core_issue #(
  parameter logic [31:0] NOP_INSN = 32'h00000013,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_insn,
  output logic [63:0] alu_pc,
  output logic [31:0] alu_insn,
  output logic [63:0] alu_src1,
  output logic [63:0] alu_src2,
  input  logic        wb_dest_enable,
  input  logic        wb_dest_long,
  input  logic [63:0] wb_dest,
  input  logic        wb_branch_target_enable,
  input  logic [63:0] wb_branch_target,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  function automatic logic [63:0] sext_word(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];

  logic [63:0] alu_pc_q, alu_pc_d;
  logic [31:0] alu_insn_q, alu_insn_d;
  logic [63:0] alu_src1_q, alu_src1_d;
  logic [63:0] alu_src2_q, alu_src2_d;
  logic        alu_valid_q, alu_valid_d;
  logic [4:0]  alu_rd_q, alu_rd_d;
  logic        alu_is_auipc_q, alu_is_auipc_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_is_auipc_q, wb_is_auipc_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        writes_rd, uses_rs1, uses_rs2;
  logic        wr_en, hazard, redirect, accept;
  logic [63:0] wb_val, src1, src2;

  assign opcode = in_insn[6:0];
  assign rd     = in_insn[11:7];
  assign rs1    = in_insn[19:15];
  assign rs2    = in_insn[24:20];

  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Writeback and bypass share one enable so a bypassed value is exactly what lands in the file
  assign wb_val = wb_dest_long ? wb_dest : sext_word(wb_dest[31:0]);
  assign wr_en  = wb_valid_q & wb_dest_enable & (wb_rd_q != 5'd0);

  always_comb begin
    src1 = '0;
    src2 = '0;
    if (rs1 != 5'd0) src1 = (wr_en && (rs1 == wb_rd_q)) ? wb_val : regs_q[rs1];
    if (rs2 != 5'd0) src2 = (wr_en && (rs2 == wb_rd_q)) ? wb_val : regs_q[rs2];
  end

  // alu_rd is only nonzero for valid rd-writing instructions, which covers the writes-rd term
  assign hazard   = alu_valid_q & (alu_rd_q != 5'd0) &
                    ((uses_rs1 & (rs1 == alu_rd_q)) | (uses_rs2 & (rs2 == alu_rd_q)));
  assign redirect = wb_valid_q & wb_branch_target_enable & ~wb_is_auipc_q;
  assign accept   = in_valid & ~hazard & ~redirect;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_rd_q] = wb_val;
  end

  always_comb begin
    alu_pc_d       = alu_pc_q;
    alu_src1_d     = alu_src1_q;
    alu_src2_d     = alu_src2_q;
    alu_insn_d     = NOP_INSN;
    alu_valid_d    = 1'b0;
    alu_rd_d       = 5'd0;
    alu_is_auipc_d = 1'b0;
    if (accept) begin
      alu_pc_d       = in_pc;
      alu_insn_d     = in_insn;
      alu_src1_d     = src1;
      alu_src2_d     = src2;
      alu_valid_d    = 1'b1;
      alu_rd_d       = writes_rd ? rd : 5'd0;
      alu_is_auipc_d = (opcode == OPC_AUIPC);
    end
    // A redirect squashes the wrong-path instruction sitting in the ALU
    wb_valid_d    = alu_valid_q & ~redirect;
    wb_rd_d       = alu_rd_q;
    wb_is_auipc_d = alu_is_auipc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      alu_pc_q       <= '0;
      alu_insn_q     <= NOP_INSN;
      alu_src1_q     <= '0;
      alu_src2_q     <= '0;
      alu_valid_q    <= 1'b0;
      alu_rd_q       <= 5'd0;
      alu_is_auipc_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_is_auipc_q  <= 1'b0;
    end else begin
      regs_q         <= regs_d;
      alu_pc_q       <= alu_pc_d;
      alu_insn_q     <= alu_insn_d;
      alu_src1_q     <= alu_src1_d;
      alu_src2_q     <= alu_src2_d;
      alu_valid_q    <= alu_valid_d;
      alu_rd_q       <= alu_rd_d;
      alu_is_auipc_q <= alu_is_auipc_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_is_auipc_q  <= wb_is_auipc_d;
    end
  end

  assign in_ready       = ~hazard & ~redirect;
  assign alu_pc         = alu_pc_q;
  assign alu_insn       = alu_insn_q;
  assign alu_src1       = alu_src1_q;
  assign alu_src2       = alu_src2_q;
  assign redirect_valid = redirect;
  assign redirect_pc    = wb_branch_target;

endmodule

// File: tb/tb_core_issue.sv
// Bench for core_issue: a small registered ALU model closes the writeback loop, and an
// architectural register model feeds a scoreboard of expected ALU-side outputs.
module tb_core_issue;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_insn;
  logic [63:0] alu_pc, alu_src1, alu_src2;
  logic [31:0] alu_insn;
  logic        wb_dest_enable, wb_dest_long, wb_branch_target_enable;
  logic [63:0] wb_dest, wb_branch_target;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  core_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn),
    .alu_pc(alu_pc), .alu_insn(alu_insn), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .wb_dest_enable(wb_dest_enable), .wb_dest_long(wb_dest_long), .wb_dest(wb_dest),
    .wb_branch_target_enable(wb_branch_target_enable), .wb_branch_target(wb_branch_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic        de;
    logic        dl;
    logic [63:0] d;
    logic        bte;
    logic [63:0] bt;
  } alu_res_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic [63:0] s1;
    logic [63:0] s2;
    bit          u1;
    bit          u2;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [63:0] mregs [32];
  alu_res_t    wb_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Subset of RV64I the scenarios use: ADDI, ADD, ADDIW, LUI, AUIPC, BEQ
  function automatic alu_res_t alu_ref(input logic [63:0] pc, input logic [31:0] insn,
                                       input logic [63:0] s1, input logic [63:0] s2);
    alu_res_t r;
    logic [63:0] ii, iu, ib;
    logic [31:0] w;
    r  = '0;
    ii = {{52{insn[31]}}, insn[31:20]};
    iu = {{32{insn[31]}}, insn[31:12], 12'h000};
    ib = {{51{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    case (insn[6:0])
      7'b0010011: begin r.de = 1'b1; r.dl = 1'b1; r.d = s1 + ii; end
      7'b0110011: begin r.de = 1'b1; r.dl = 1'b1; r.d = s1 + s2; end
      7'b0011011: begin
        w = s1[31:0] + ii[31:0];
        r.de = 1'b1; r.dl = 1'b0; r.d = {32'h0, w};
      end
      7'b0110111: begin r.de = 1'b1; r.dl = 1'b1; r.d = iu; end
      7'b0010111: begin
        r.de = 1'b1; r.dl = 1'b1; r.d = pc + iu;
        r.bte = 1'b1; r.bt = pc + iu;
      end
      7'b1100011: begin r.bte = (s1 == s2); r.bt = pc + ib; end
      default: ;
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) wb_r <= '0;
    else       wb_r <= alu_ref(alu_pc, alu_insn, alu_src1, alu_src2);
  end

  assign wb_dest_enable          = wb_r.de;
  assign wb_dest_long            = wb_r.dl;
  assign wb_dest                 = wb_r.d;
  assign wb_branch_target_enable = wb_r.bte;
  assign wb_branch_target        = wb_r.bt;

  function automatic logic [31:0] i_add(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] i_addiw(input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0011011};
  endfunction
  function automatic logic [31:0] i_lui(input int rd, input logic [19:0] imm);
    return {imm, rd[4:0], 7'b0110111};
  endfunction
  function automatic logic [31:0] i_auipc(input int rd, input logic [19:0] imm);
    return {imm, rd[4:0], 7'b0010111};
  endfunction
  function automatic logic [31:0] i_beq(input int rs1, input int rs2, input int off);
    return {off[12], off[10:5], rs2[4:0], rs1[4:0], 3'b000, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic bit uses1(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b1100111, 7'b1100011};
  endfunction
  function automatic bit uses2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0111011, 7'b1100011};
  endfunction

  // Present one instruction, wait (bounded) for acceptance, push its expected ALU view
  task automatic issue(input logic [63:0] pc, input logic [31:0] insn,
                       input int exp_stall, input bit wrong_path);
    int       stalls = 0;
    bit       ok = 1'b0;
    exp_t     e;
    alu_res_t r;
    @(negedge clk);
    in_valid = 1'b1;
    in_pc    = pc;
    in_insn  = insn;
    for (int k = 0; k < 6 && !ok; k++) begin
      #1;
      if (in_ready) ok = 1'b1;
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!ok) begin
      chk("ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      chk("stall_cycles", 64'(stalls), 64'(exp_stall));
      e.pc   = pc;
      e.insn = insn;
      e.s1   = mregs[insn[19:15]];
      e.s2   = mregs[insn[24:20]];
      e.u1   = uses1(insn[6:0]);
      e.u2   = uses2(insn[6:0]);
      sbq.push_back(e);
      r = alu_ref(pc, insn, e.s1, e.s2);
      if (!wrong_path && r.de && insn[11:7] != 5'd0)
        mregs[insn[11:7]] = r.dl ? r.d : {{32{r.d[31]}}, r.d[31:0]};
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle_chk_redirect(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("redirect_quiet", 64'(redirect_valid), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && alu_insn !== NOP) begin
      if (sbq.size() == 0) chk("unexpected_issue", {32'h0, alu_insn}, {32'h0, NOP});
      else begin
        mon_e = sbq.pop_front();
        chk("alu_pc", alu_pc, mon_e.pc);
        chk("alu_insn", {32'h0, alu_insn}, {32'h0, mon_e.insn});
        if (mon_e.u1) chk("alu_src1", alu_src1, mon_e.s1);
        if (mon_e.u2) chk("alu_src2", alu_src2, mon_e.s2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_pc    = '0;
    in_insn  = NOP;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alu_insn", {32'h0, alu_insn}, {32'h0, NOP});
    chk("rst_alu_pc", alu_pc, 64'd0);
    chk("rst_src1", alu_src1, 64'd0);
    chk("rst_src2", alu_src2, 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // RAW stall then bypass; later a plain register-file read
    issue(64'h1000, 32'h00500093, 0, 1'b0);
    issue(64'h1004, 32'h00108133, 1, 1'b0);
    chk("raw_src1", alu_src1, 64'd5);
    chk("raw_src2", alu_src2, 64'd5);
    issue(64'h1008, i_add(10, 2, 0), 1, 1'b0);
    idle_chk_redirect(2);
    issue(64'h100C, i_add(16, 2, 2), 0, 1'b0);
    chk("x2_regfile", alu_src1, 64'd10);

    // 32-bit result sign-extended on writeback
    issue(64'h1010, i_lui(9, 20'h80000), 0, 1'b0);
    issue(64'h1014, i_addiw(3, 9, 0), 1, 1'b0);
    issue(64'h1018, i_add(4, 3, 0), 1, 1'b0);
    chk("addiw_sext", alu_src1, 64'hFFFF_FFFF_8000_0000);

    // Taken branch redirects and squashes the wrong-path ADDI
    issue(64'h100, i_beq(0, 0, 16), 0, 1'b0);
    issue(64'h104, i_addi(5, 0, 7), 0, 1'b1);
    @(negedge clk);
    #1;
    chk("br_redirect", 64'(redirect_valid), 64'd1);
    chk("br_target", redirect_pc, 64'h110);
    chk("br_ready", 64'(in_ready), 64'd0);
    idle_chk_redirect(1);
    issue(64'h110, i_add(11, 5, 0), 0, 1'b0);
    chk("x5_squashed", alu_src1, 64'd0);

    // AUIPC raises branch_target_enable but must not redirect
    issue(64'h200, i_auipc(6, 20'h1), 0, 1'b0);
    idle_chk_redirect(2);
    issue(64'h204, i_add(12, 6, 0), 0, 1'b0);
    chk("auipc_x6", alu_src1, 64'h1200);

    // Writes to x0 are dropped and never stall
    issue(64'h300, i_addi(0, 0, 9), 0, 1'b0);
    issue(64'h304, i_add(7, 0, 0), 0, 1'b0);
    chk("x0_bypass", alu_src1, 64'd0);
    idle_chk_redirect(2);
    issue(64'h308, i_add(17, 0, 0), 0, 1'b0);
    chk("x0_regfile", alu_src1, 64'd0);

    // Reset in the middle of a stall
    issue(64'h400, i_addi(13, 0, 3), 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_pc    = 64'h404;
    in_insn  = i_add(14, 13, 13);
    #1;
    chk("pre_rst_stall", 64'(in_ready), 64'd0);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_insn", {32'h0, alu_insn}, {32'h0, NOP});
    chk("midrst_redirect", 64'(redirect_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(64'h500, i_add(15, 13, 0), 0, 1'b0);
    chk("x13_not_written", alu_src1, 64'd0);

    idle_chk_redirect(2);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
